pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen.sv | 144 ++++++++++++++
 tb/tb_pc_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen: fetch program counter with branch/jump/eret redirection and exception entry.
// Latency: a redirect appears on pc one edge after the request when stall=0; pc4/adel are combinational from pc.
// Backpressure: stall holds pc; a redirect seen under stall is latched (newest wins) and applied on release.
//
// Ports:
//   clk, reset (async active-low)            clock and reset
//   stall                                    hold the fetch pc this cycle
//   npc_op, br_taken                         next-pc operation (000 seq, 001 branch, 010 j, 011 jr, 100 eret)
//   exc_req                                  exception/interrupt entry, overrides everything
//   base_pc, imm16, imm26, reg_addr, epc     target operands from the decode stage
//   pc, pc4                                  registered fetch pc and pc+4
//   redirect_pending                         a latched redirect is waiting for stall to drop
//   adel                                     current pc is misaligned or outside instruction memory
module pc_gen #(
  parameter int             W        = 32,
  parameter logic [W-1:0]   RESET_PC = W'(32'h0000_3000),
  parameter logic [W-1:0]   EXC_PC   = W'(32'h0000_4180),
  parameter logic [W-1:0]   IM_BASE  = W'(32'h0000_3000),
  parameter int             IM_WORDS = 4096
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic [2:0]   npc_op,
  input  logic         br_taken,
  input  logic         exc_req,
  input  logic [W-1:0] base_pc,
  input  logic [15:0]  imm16,
  input  logic [25:0]  imm26,
  input  logic [W-1:0] reg_addr,
  input  logic [W-1:0] epc,
  output logic [W-1:0] pc,
  output logic [W-1:0] pc4,
  output logic         redirect_pending,
  output logic         adel
);

  localparam logic [2:0] OP_BR   = 3'b001;
  localparam logic [2:0] OP_J    = 3'b010;
  localparam logic [2:0] OP_JR   = 3'b011;
  localparam logic [2:0] OP_ERET = 3'b100;

  // One extra bit so the end of instruction memory cannot wrap to zero.
  localparam logic [W:0] IM_LIMIT = {1'b0, IM_BASE} + ((W+1)'(IM_WORDS) << 2);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] lat_q, lat_d;
  logic [W-1:0] seq_base;
  logic [W-1:0] br_tgt;
  logic [W-1:0] j_tgt;
  logic [W-1:0] redir_tgt;
  logic         redir_req;

  assign seq_base = base_pc + W'(4);
  assign br_tgt   = seq_base + {{(W-18){imm16[15]}}, imm16, 2'b00};

  // j keeps the region bits above bit 27 of the delay-slot address; with W=28 there are none.
  generate
    if (W > 28) begin : g_j_region
      assign j_tgt = {seq_base[W-1:28], imm26, 2'b00};
    end else begin : g_j_flat
      assign j_tgt = {imm26, 2'b00};
    end
  endgenerate

  // Decode the operation; a not-taken branch and the reserved codes fall through as sequential.
  always_comb begin
    redir_req = 1'b0;
    redir_tgt = '0;
    case (npc_op)
      OP_BR: begin
        redir_req = br_taken;
        redir_tgt = br_tgt;
      end
      OP_J: begin
        redir_req = 1'b1;
        redir_tgt = j_tgt;
      end
      OP_JR: begin
        redir_req = 1'b1;
        redir_tgt = reg_addr;
      end
      OP_ERET: begin
        redir_req = 1'b1;
        redir_tgt = epc;
      end
      default: begin
        redir_req = 1'b0;
        redir_tgt = '0;
      end
    endcase
  end

  // Next-pc selection and RUN/HOLD transitions.
  always_comb begin
    pc_d    = pc_q + W'(4);
    lat_d   = lat_q;
    state_d = state_q;
    if (exc_req) begin
      pc_d    = EXC_PC;
      state_d = RUN;
    end else if (stall) begin
      pc_d = pc_q;
      if (redir_req) begin
        // Latest request replaces any earlier latched target.
        lat_d   = redir_tgt;
        state_d = HOLD;
      end
    end else begin
      state_d = RUN;
      if (redir_req) begin
        pc_d = redir_tgt;
      end else if (state_q == HOLD) begin
        pc_d = lat_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      lat_q   <= lat_d;
    end
  end

  assign pc               = pc_q;
  assign pc4              = pc_q + W'(4);
  assign redirect_pending = (state_q == HOLD);

  // Purely informational: sequencing continues regardless of adel.
  assign adel = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || ({1'b0, pc_q} >= IM_LIMIT);

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [2:0]  npc_op;
  logic        br_taken;
  logic        exc_req;
  logic [31:0] base_pc;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] reg_addr;
  logic [31:0] epc;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        redirect_pending;
  logic        adel;

  int n_checks;
  int n_fail;

  pc_gen dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .npc_op           (npc_op),
    .br_taken         (br_taken),
    .exc_req          (exc_req),
    .base_pc          (base_pc),
    .imm16            (imm16),
    .imm26            (imm26),
    .reg_addr         (reg_addr),
    .epc              (epc),
    .pc               (pc),
    .pc4              (pc4),
    .redirect_pending (redirect_pending),
    .adel             (adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [2:0]  op;
    logic        bt;
    logic        exc;
    logic [31:0] base;
    logic [15:0] i16;
    logic [25:0] i26;
    logic [31:0] raddr;
    logic [31:0] ep;
    logic [31:0] exp_pc;
    logic        exp_pend;
    logic        exp_adel;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input logic s, input logic [2:0] op, input logic bt, input logic x,
                              input logic [31:0] b, input logic [15:0] i16, input logic [25:0] i26,
                              input logic [31:0] ra, input logic [31:0] ep,
                              input logic [31:0] epc_exp, input logic pend, input logic ad);
    vec_t r;
    r.stall = s; r.op = op; r.bt = bt; r.exc = x; r.base = b; r.i16 = i16; r.i26 = i26;
    r.raddr = ra; r.ep = ep; r.exp_pc = epc_exp; r.exp_pend = pend; r.exp_adel = ad;
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic [2:0] op, input logic bt, input logic x,
                       input logic [31:0] b, input logic [15:0] i16, input logic [25:0] i26,
                       input logic [31:0] ra, input logic [31:0] ep);
    stall = s; npc_op = op; br_taken = bt; exc_req = x; base_pc = b;
    imm16 = i16; imm26 = i26; reg_addr = ra; epc = ep;
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: architectural rules written directly as arithmetic.
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_lat;

  function automatic logic m_is_redir(input logic [2:0] op, input logic bt);
    return (op == 3'd1 && bt) || op == 3'd2 || op == 3'd3 || op == 3'd4;
  endfunction

  function automatic logic [31:0] m_target(input logic [2:0] op, input logic [31:0] b,
                                           input logic [15:0] i16, input logic [25:0] i26,
                                           input logic [31:0] ra, input logic [31:0] ep);
    longint signed off;
    longint unsigned t;
    case (op)
      3'd1: begin
        off = longint'($signed(i16)) * 4;
        t   = longint'(b) + 4 + longint'(off);
        return t[31:0];
      end
      3'd2: begin
        t = longint'(b) + 4;
        return (t[31:0] & 32'hF000_0000) | (32'(i26) * 4);
      end
      3'd3: return ra;
      default: return ep;
    endcase
  endfunction

  function automatic logic m_adel(input logic [31:0] p);
    return (p % 4 != 0) || (p < 32'h3000) || (longint'(p) >= longint'(32'h3000) + 4 * 4096);
  endfunction

  task automatic model_edge();
    logic        rq;
    logic [31:0] t;
    rq = m_is_redir(npc_op, br_taken);
    t  = m_target(npc_op, base_pc, imm16, imm26, reg_addr, epc);
    if (exc_req) begin
      m_pc = 32'h4180; m_pend = 1'b0;
    end else if (stall) begin
      if (rq) begin
        m_lat = t; m_pend = 1'b1;
      end
    end else begin
      if (rq)          m_pc = t;
      else if (m_pend) m_pc = m_lat;
      else             m_pc = m_pc + 32'd4;
      m_pend = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0);

    //            stall op    bt    exc   base           imm16     imm26        reg_addr       epc            exp_pc         pend  adel
    tbl[0]  = mk(1'b0, 3'd0, 1'b0, 1'b0, 32'h0,          16'h0,    26'h0,       32'h0,         32'h0,         32'h0000_3004, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 3'd0, 1'b0, 1'b0, 32'h0,          16'h0,    26'h0,       32'h0,         32'h0,         32'h0000_3008, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 3'd0, 1'b0, 1'b0, 32'h0,          16'h0,    26'h0,       32'h0,         32'h0,         32'h0000_300C, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 3'd1, 1'b1, 1'b0, 32'h0000_3010,  16'hFFFC, 26'h0,       32'h0,         32'h0,         32'h0000_3004, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 3'd1, 1'b0, 1'b0, 32'h0000_3010,  16'hFFFC, 26'h0,       32'h0,         32'h0,         32'h0000_3008, 1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 3'd2, 1'b0, 1'b0, 32'hFFFF_FF00,  16'h0,    26'h3F0_F00F,32'h0,         32'h0,         32'hFFC3_C03C, 1'b0, 1'b1);
    tbl[6]  = mk(1'b0, 3'd3, 1'b0, 1'b0, 32'h0,          16'h0,    26'h0,       32'h0000_3002, 32'h0,         32'h0000_3002, 1'b0, 1'b1);
    tbl[7]  = mk(1'b1, 3'd3, 1'b0, 1'b0, 32'h0,          16'h0,    26'h0,       32'h0000_3400, 32'h0,         32'h0000_3002, 1'b1, 1'b1);
    tbl[8]  = mk(1'b1, 3'd3, 1'b0, 1'b0, 32'h0,          16'h0,    26'h0,       32'h0000_3400, 32'h0,         32'h0000_3002, 1'b1, 1'b1);
    tbl[9]  = mk(1'b0, 3'd0, 1'b0, 1'b0, 32'h0,          16'h0,    26'h0,       32'h0,         32'h0,         32'h0000_3400, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 3'd3, 1'b0, 1'b0, 32'h0,          16'h0,    26'h0,       32'h0000_3800, 32'h0,         32'h0000_3400, 1'b1, 1'b0);
    tbl[11] = mk(1'b1, 3'd3, 1'b0, 1'b1, 32'h0,          16'h0,    26'h0,       32'h0000_3800, 32'h0,         32'h0000_4180, 1'b0, 1'b0);
    tbl[12] = mk(1'b0, 3'd4, 1'b0, 1'b0, 32'h0,          16'h0,    26'h0,       32'h0,         32'h0000_3008, 32'h0000_3008, 1'b0, 1'b0);
    tbl[13] = mk(1'b1, 3'd1, 1'b1, 1'b0, 32'h0000_3100,  16'h0002, 26'h0,       32'h0,         32'h0,         32'h0000_3008, 1'b1, 1'b0);
    tbl[14] = mk(1'b1, 3'd3, 1'b0, 1'b0, 32'h0,          16'h0,    26'h0,       32'h0000_3200, 32'h0,         32'h0000_3008, 1'b1, 1'b0);
    tbl[15] = mk(1'b0, 3'd5, 1'b0, 1'b0, 32'h0,          16'h0,    26'h0,       32'h0,         32'h0,         32'h0000_3200, 1'b0, 1'b0);
    tbl[16] = mk(1'b1, 3'd3, 1'b0, 1'b0, 32'h0,          16'h0,    26'h0,       32'h0000_3500, 32'h0,         32'h0000_3200, 1'b1, 1'b0);
    tbl[17] = mk(1'b0, 3'd3, 1'b0, 1'b0, 32'h0,          16'h0,    26'h0,       32'h0000_3600, 32'h0,         32'h0000_3600, 1'b0, 1'b0);
    tbl[18] = mk(1'b1, 3'd0, 1'b0, 1'b0, 32'h0,          16'h0,    26'h0,       32'h0,         32'h0,         32'h0000_3600, 1'b0, 1'b0);

    // Reset state.
    #12;
    check("reset_pc",   pc, 32'h0000_3000);
    check("reset_pc4",  pc4, 32'h0000_3004);
    check("reset_pend", 32'(redirect_pending), 32'd0);
    check("reset_adel", 32'(adel), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed table.
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].stall, tbl[i].op, tbl[i].bt, tbl[i].exc, tbl[i].base,
            tbl[i].i16, tbl[i].i26, tbl[i].raddr, tbl[i].ep);
      step();
      check($sformatf("vec%0d_pc", i),   pc, tbl[i].exp_pc);
      check($sformatf("vec%0d_pend", i), 32'(redirect_pending), 32'(tbl[i].exp_pend));
      check($sformatf("vec%0d_adel", i), 32'(adel), 32'(tbl[i].exp_adel));
      check($sformatf("vec%0d_pc4", i),  pc4, tbl[i].exp_pc + 32'd4);
    end

    // Reset asserted mid-HOLD discards the pending redirect.
    drive(1'b1, 3'd3, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0000_3400, 32'h0);
    step();
    check("hold_before_reset_pend", 32'(redirect_pending), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_pc",   pc, 32'h0000_3000);
    check("async_reset_pend", 32'(redirect_pending), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0);
    step();
    check("post_reset_seq_pc",   pc, 32'h0000_3004);
    check("post_reset_seq_pend", 32'(redirect_pending), 32'd0);

    // Branch target wraps modulo 2^32.
    drive(1'b0, 3'd1, 1'b1, 1'b0, 32'hFFFF_FFFC, 16'h0000, 26'h0, 32'h0, 32'h0);
    step();
    check("wrap_pc",   pc, 32'h0000_0000);
    check("wrap_adel", 32'(adel), 32'd1);
    check("wrap_pc4",  pc4, 32'h0000_0004);

    // Randomized phase against the reference model, starting from a fresh reset.
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    m_pc = 32'h3000; m_pend = 1'b0; m_lat = 32'h0;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] b, ra, ep;
      b  = ($urandom_range(0, 3) != 0) ? 32'h3000 + 4 * $urandom_range(0, 4095) : $urandom;
      ra = ($urandom_range(0, 3) != 0) ? 32'h3000 + 4 * $urandom_range(0, 4095) : $urandom;
      ep = ($urandom_range(0, 3) != 0) ? 32'h3000 + 4 * $urandom_range(0, 4095) : $urandom;
      drive(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), 1'($urandom),
            ($urandom_range(0, 15) == 0), b, 16'($urandom), 26'($urandom), ra, ep);
      model_edge();
      step();
      check("rand_pc",   pc, m_pc);
      check("rand_pend", 32'(redirect_pending), 32'(m_pend));
      check("rand_pc4",  pc4, m_pc + 32'd4);
      check("rand_adel", 32'(adel), 32'(m_adel(m_pc)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
